// File: rtl/nearest_centroid_if.sv
// Bundle of pixel handshake, centroid buses, distance-unit link and result
// outputs for the nearest_centroid k-means assignment stage.
interface nearest_centroid_if #(
  parameter int NUM_CLUSTERS = 4,
  parameter int IDX_W        = $clog2(NUM_CLUSTERS)
);
  logic                      pixel_valid_in;
  logic                      pixel_ready_out;
  logic [8:0]                pixel_x_in;
  logic [7:0]                pixel_y_in;
  logic [NUM_CLUSTERS*9-1:0] centroid_x_in;
  logic [NUM_CLUSTERS*8-1:0] centroid_y_in;
  logic                      dist_valid_out;
  logic [8:0]                dist_x1_out;
  logic [7:0]                dist_y1_out;
  logic [8:0]                dist_x2_out;
  logic [7:0]                dist_y2_out;
  logic                      dist_valid_in;
  logic [8:0]                dist_in;
  logic                      cluster_valid_out;
  logic [IDX_W-1:0]          cluster_idx_out;
  logic [8:0]                min_dist_out;
  logic [8:0]                pixel_x_out;
  logic [7:0]                pixel_y_out;

  modport slave (
    input  pixel_valid_in, pixel_x_in, pixel_y_in, centroid_x_in, centroid_y_in,
           dist_valid_in, dist_in,
    output pixel_ready_out, dist_valid_out, dist_x1_out, dist_y1_out,
           dist_x2_out, dist_y2_out, cluster_valid_out, cluster_idx_out,
           min_dist_out, pixel_x_out, pixel_y_out
  );

  modport master (
    output pixel_valid_in, pixel_x_in, pixel_y_in, centroid_x_in, centroid_y_in,
           dist_valid_in, dist_in,
    input  pixel_ready_out, dist_valid_out, dist_x1_out, dist_y1_out,
           dist_x2_out, dist_y2_out, cluster_valid_out, cluster_idx_out,
           min_dist_out, pixel_x_out, pixel_y_out
  );
endinterface

// File: rtl/nearest_centroid.sv
// K-means assignment stage: streams one pixel against every centroid through
// a shared 1-cycle manhattan distance unit and reports the closest cluster.
module nearest_centroid #(
  parameter int NUM_CLUSTERS = 4,
  parameter int IDX_W        = $clog2(NUM_CLUSTERS)
) (
  input logic              clk_in,
  input logic              rst_n_in,
  nearest_centroid_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLUSTERS - 1);

  state_t           state, state_nxt;
  logic [8:0]       pix_x;
  logic [7:0]       pix_y;
  logic [8:0]       cent_x [NUM_CLUSTERS];
  logic [7:0]       cent_y [NUM_CLUSTERS];
  logic [IDX_W-1:0] issue_idx;
  logic [IDX_W-1:0] rcv_idx;
  logic [IDX_W-1:0] best_idx;
  logic [8:0]       min_dist;

  logic             accept;
  logic             collect;
  logic             last_rcv;
  logic             take_new;
  logic [8:0]       nxt_dist;
  logic [IDX_W-1:0] nxt_idx;

  // First distance always seeds the minimum; later ones win only when
  // strictly smaller, so ties stay with the lower index.
  function automatic logic is_closer(input logic first, input logic [8:0] cand,
                                     input logic [8:0] best);
    return first || (cand < best);
  endfunction

  assign accept   = (state == IDLE) && bus.pixel_valid_in;
  assign collect  = ((state == ISSUE) || (state == WAIT)) && bus.dist_valid_in;
  assign last_rcv = collect && (rcv_idx == LAST_IDX);
  assign take_new = is_closer(rcv_idx == '0, bus.dist_in, min_dist);
  assign nxt_dist = take_new ? bus.dist_in : min_dist;
  assign nxt_idx  = take_new ? rcv_idx : best_idx;

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state: issue all centroids back to back, then drain the last distance
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (issue_idx == LAST_IDX) state_nxt = WAIT;
      WAIT:    if (last_rcv) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state: handshake and distance-unit request
  always_comb begin
    bus.pixel_ready_out = 1'b0;
    bus.dist_valid_out  = 1'b0;
    bus.dist_x1_out     = '0;
    bus.dist_y1_out     = '0;
    bus.dist_x2_out     = '0;
    bus.dist_y2_out     = '0;
    case (state)
      IDLE:  bus.pixel_ready_out = 1'b1;
      ISSUE: begin
        bus.dist_valid_out = 1'b1;
        bus.dist_x1_out    = pix_x;
        bus.dist_y1_out    = pix_y;
        bus.dist_x2_out    = cent_x[issue_idx];
        bus.dist_y2_out    = cent_y[issue_idx];
      end
      default: ;
    endcase
  end

  // Snapshot pixel and centroids at accept so bus changes cannot disturb the pixel in flight
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pix_x <= '0;
      pix_y <= '0;
      for (int k = 0; k < NUM_CLUSTERS; k++) begin
        cent_x[k] <= '0;
        cent_y[k] <= '0;
      end
    end else if (accept) begin
      pix_x <= bus.pixel_x_in;
      pix_y <= bus.pixel_y_in;
      for (int k = 0; k < NUM_CLUSTERS; k++) begin
        cent_x[k] <= bus.centroid_x_in[9*k +: 9];
        cent_y[k] <= bus.centroid_y_in[8*k +: 8];
      end
    end
  end

  // Request counter: one centroid per cycle while issuing
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)            issue_idx <= '0;
    else if (accept)          issue_idx <= '0;
    else if (state == ISSUE)  issue_idx <= issue_idx + IDX_W'(1);
  end

  // Running minimum over the returned distance stream
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rcv_idx  <= '0;
      min_dist <= '0;
      best_idx <= '0;
    end else if (accept) begin
      rcv_idx  <= '0;
    end else if (collect) begin
      rcv_idx  <= rcv_idx + IDX_W'(1);
      min_dist <= nxt_dist;
      best_idx <= nxt_idx;
    end
  end

  // Result registers: pulse once when the last distance is consumed, then hold
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.cluster_valid_out <= 1'b0;
      bus.cluster_idx_out   <= '0;
      bus.min_dist_out      <= '0;
      bus.pixel_x_out       <= '0;
      bus.pixel_y_out       <= '0;
    end else begin
      bus.cluster_valid_out <= last_rcv;
      if (last_rcv) begin
        bus.cluster_idx_out <= nxt_idx;
        bus.min_dist_out    <= nxt_dist;
        bus.pixel_x_out     <= pix_x;
        bus.pixel_y_out     <= pix_y;
      end
    end
  end

endmodule

// File: tb/tb_nearest_centroid.sv
// Directed bench for nearest_centroid with a behavioural 1-cycle manhattan
// distance unit attached to the request/response link.
module tb_nearest_centroid;

  localparam int K = 4;
  localparam int IW = $clog2(K);

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  nearest_centroid_if #(.NUM_CLUSTERS(K)) bus ();

  nearest_centroid #(.NUM_CLUSTERS(K)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] mdist(input logic [8:0] x1, input logic [7:0] y1,
                                       input logic [8:0] x2, input logic [7:0] y2);
    int dx, dy;
    dx = (x1 > x2) ? int'(x1) - int'(x2) : int'(x2) - int'(x1);
    dy = (y1 > y2) ? int'(y1) - int'(y2) : int'(y2) - int'(y1);
    return 9'(dx + dy);
  endfunction

  // distance unit model: registered result one cycle after the request
  always @(posedge clk) begin
    bus.dist_valid_in <= bus.dist_valid_out;
    bus.dist_in       <= mdist(bus.dist_x1_out, bus.dist_y1_out,
                               bus.dist_x2_out, bus.dist_y2_out);
  end

  // observations from run_pixel
  bit          obs_acc;
  int          obs_lat;
  int          obs_pulses;
  logic [IW-1:0] obs_idx;
  logic [8:0]  obs_dist;
  logic [8:0]  obs_x;
  logic [7:0]  obs_y;

  task automatic set_cents(input logic [8:0] x0, x1, x2, x3,
                           input logic [7:0] y0, y1, y2, y3);
    bus.centroid_x_in = {x3, x2, x1, x0};
    bus.centroid_y_in = {y3, y2, y1, y0};
  endtask

  task automatic set_scene1();
    set_cents(9'd10, 9'd100, 9'd200, 9'd300, 8'd10, 8'd50, 8'd200, 8'd20);
  endtask

  // Drives one pixel from a negedge and records what comes back; no checking here.
  task automatic run_pixel(input logic [8:0] px, input logic [7:0] py, input bit scramble);
    obs_acc = 0; obs_lat = -1; obs_pulses = 0;
    bus.pixel_x_in = px;
    bus.pixel_y_in = py;
    bus.pixel_valid_in = 1'b1;
    for (int i = 0; i < 20 && !obs_acc; i++) begin
      if (bus.pixel_ready_out === 1'b1) obs_acc = 1;
      else @(negedge clk);
    end
    if (!obs_acc) begin
      bus.pixel_valid_in = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.pixel_valid_in = 1'b0;
    if (scramble) bus.centroid_x_in = '0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.cluster_valid_out === 1'b1) begin
        obs_pulses++;
        if (obs_lat < 0) obs_lat = k - 1;
        obs_idx  = bus.cluster_idx_out;
        obs_dist = bus.min_dist_out;
        obs_x    = bus.pixel_x_out;
        obs_y    = bus.pixel_y_out;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pixel_valid_in = 1'b0;
    bus.pixel_x_in = '0;
    bus.pixel_y_in = '0;
    bus.centroid_x_in = '0;
    bus.centroid_y_in = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.pixel_ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", bus.pixel_ready_out); end
    n_cmp++; if (bus.dist_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_dist_valid: got %b expected 0", bus.dist_valid_out); end
    n_cmp++; if (bus.cluster_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_cluster_valid: got %b expected 0", bus.cluster_valid_out); end
    n_cmp++; if (bus.min_dist_out !== 9'd0 || bus.cluster_idx_out !== '0) begin n_bad++; $display("FAIL reset_result: got idx %0d dist %0d expected 0 0", bus.cluster_idx_out, bus.min_dist_out); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_scene1();
    run_pixel(9'd105, 8'd48, 1'b0);
    n_cmp++; if (obs_acc !== 1'b1) begin n_bad++; $display("FAIL basic_accept: got %0d expected 1", obs_acc); end
    n_cmp++; if (obs_lat !== 5) begin n_bad++; $display("FAIL basic_latency: got %0d expected 5", obs_lat); end
    n_cmp++; if (obs_pulses !== 1) begin n_bad++; $display("FAIL basic_pulses: got %0d expected 1", obs_pulses); end
    n_cmp++; if (obs_idx !== 2'd1) begin n_bad++; $display("FAIL basic_idx: got %0d expected 1", obs_idx); end
    n_cmp++; if (obs_dist !== 9'd7) begin n_bad++; $display("FAIL basic_dist: got %0d expected 7", obs_dist); end
    n_cmp++; if (obs_x !== 9'd105 || obs_y !== 8'd48) begin n_bad++; $display("FAIL basic_echo: got (%0d,%0d) expected (105,48)", obs_x, obs_y); end
    n_cmp++; if (bus.min_dist_out !== 9'd7) begin n_bad++; $display("FAIL basic_hold: got %0d expected 7", bus.min_dist_out); end
  endtask

  task automatic test_tie();
    set_cents(9'd0, 9'd20, 9'd50, 9'd80, 8'd0, 8'd0, 8'd50, 8'd80);
    run_pixel(9'd10, 8'd0, 1'b0);
    n_cmp++; if (obs_idx !== 2'd0) begin n_bad++; $display("FAIL tie_idx: got %0d expected 0", obs_idx); end
    n_cmp++; if (obs_dist !== 9'd10) begin n_bad++; $display("FAIL tie_dist: got %0d expected 10", obs_dist); end
  endtask

  task automatic test_last_exact();
    set_scene1();
    run_pixel(9'd300, 8'd20, 1'b0);
    n_cmp++; if (obs_idx !== 2'd3) begin n_bad++; $display("FAIL last_idx: got %0d expected 3", obs_idx); end
    n_cmp++; if (obs_dist !== 9'd0) begin n_bad++; $display("FAIL last_dist: got %0d expected 0", obs_dist); end
  endtask

  task automatic test_back_to_back();
    logic [8:0]    px [3];
    logic [7:0]    py [3];
    logic [IW-1:0] e_idx [3];
    logic [8:0]    e_dist [3];
    logic [IW-1:0] r_idx [3];
    logic [8:0]    r_dist [3];
    int acc_c [3];
    int na, nr, wide;
    bit prev_cv, accepted;
    px = '{9'd105, 9'd300, 9'd12};
    py = '{8'd48, 8'd20, 8'd9};
    e_idx = '{2'd1, 2'd3, 2'd0};
    e_dist = '{9'd7, 9'd0, 9'd3};
    na = 0; nr = 0; wide = 0; prev_cv = 0;
    set_scene1();
    bus.pixel_x_in = px[0];
    bus.pixel_y_in = py[0];
    bus.pixel_valid_in = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus.cluster_valid_out === 1'b1) begin
        if (prev_cv) wide++;
        if (nr < 3) begin
          r_idx[nr] = bus.cluster_idx_out;
          r_dist[nr] = bus.min_dist_out;
        end
        nr++;
      end
      prev_cv = (bus.cluster_valid_out === 1'b1);
      accepted = bus.pixel_valid_in && (bus.pixel_ready_out === 1'b1);
      if (accepted && na < 3) acc_c[na] = c;
      @(negedge clk);
      if (accepted) begin
        na++;
        if (na < 3) begin
          bus.pixel_x_in = px[na];
          bus.pixel_y_in = py[na];
        end else begin
          bus.pixel_valid_in = 1'b0;
        end
      end
    end
    bus.pixel_valid_in = 1'b0;
    n_cmp++; if (na !== 3) begin n_bad++; $display("FAIL b2b_accepts: got %0d expected 3", na); end
    n_cmp++; if (nr !== 3) begin n_bad++; $display("FAIL b2b_results: got %0d expected 3", nr); end
    n_cmp++; if (wide !== 0) begin n_bad++; $display("FAIL b2b_pulse_width: got %0d wide cycles expected 0", wide); end
    if (na == 3) begin
      n_cmp++; if (acc_c[1] - acc_c[0] !== 6) begin n_bad++; $display("FAIL b2b_gap01: got %0d expected 6", acc_c[1] - acc_c[0]); end
      n_cmp++; if (acc_c[2] - acc_c[1] !== 6) begin n_bad++; $display("FAIL b2b_gap12: got %0d expected 6", acc_c[2] - acc_c[1]); end
    end
    for (int i = 0; i < 3 && i < nr; i++) begin
      n_cmp++; if (r_idx[i] !== e_idx[i] || r_dist[i] !== e_dist[i]) begin
        n_bad++; $display("FAIL b2b_result%0d: got idx %0d dist %0d expected idx %0d dist %0d", i, r_idx[i], r_dist[i], e_idx[i], e_dist[i]);
      end
    end
  endtask

  task automatic test_latch();
    set_scene1();
    run_pixel(9'd105, 8'd48, 1'b1);
    n_cmp++; if (obs_idx !== 2'd1) begin n_bad++; $display("FAIL latch_idx: got %0d expected 1", obs_idx); end
    n_cmp++; if (obs_dist !== 9'd7) begin n_bad++; $display("FAIL latch_dist: got %0d expected 7", obs_dist); end
  endtask

  task automatic test_mid_reset();
    int stray;
    bit got;
    set_scene1();
    bus.pixel_x_in = 9'd105;
    bus.pixel_y_in = 8'd48;
    bus.pixel_valid_in = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.pixel_ready_out === 1'b1) got = 1;
      else @(negedge clk);
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL mrst_accept: got 0 expected 1"); end
    @(posedge clk);
    @(negedge clk);
    bus.pixel_valid_in = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.dist_valid_out !== 1'b1) begin n_bad++; $display("FAIL mrst_issuing: got %b expected 1", bus.dist_valid_out); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.pixel_ready_out !== 1'b1) begin n_bad++; $display("FAIL mrst_ready: got %b expected 1", bus.pixel_ready_out); end
    n_cmp++; if (bus.dist_valid_out !== 1'b0) begin n_bad++; $display("FAIL mrst_dist_valid: got %b expected 0", bus.dist_valid_out); end
    n_cmp++; if (bus.cluster_idx_out !== '0 || bus.min_dist_out !== 9'd0) begin n_bad++; $display("FAIL mrst_result: got idx %0d dist %0d expected 0 0", bus.cluster_idx_out, bus.min_dist_out); end
    n_cmp++; if (bus.pixel_x_out !== 9'd0 || bus.pixel_y_out !== 8'd0) begin n_bad++; $display("FAIL mrst_echo: got (%0d,%0d) expected (0,0)", bus.pixel_x_out, bus.pixel_y_out); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.cluster_valid_out === 1'b1) stray++;
    end
    n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL mrst_no_result: got %0d pulses expected 0", stray); end
    run_pixel(9'd105, 8'd48, 1'b0);
    n_cmp++; if (obs_idx !== 2'd1 || obs_dist !== 9'd7) begin n_bad++; $display("FAIL mrst_next: got idx %0d dist %0d expected idx 1 dist 7", obs_idx, obs_dist); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_tie();
    test_last_exact();
    test_back_to_back();
    test_latch();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nearest_centroid.md
Name: nearest_centroid

Overview:
- K-means assignment stage. Accepts one pixel coordinate and compares it against NUM_CLUSTERS centroids by driving the shared manhattan distance unit, one centroid per cycle.
- Consumes the unit's distance stream (1-cycle latency), tracks the running minimum and emits the winning cluster index.
- Sits between the pixel source and the centroid accumulator/update logic.

Parameters:
- NUM_CLUSTERS, 4, number of centroids compared per pixel (2..16).
- IDX_W, $clog2(NUM_CLUSTERS), width of the cluster index.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset; asynchronous assert, active-low.
- pixel_valid_in  input  1  pixel coordinate valid.
- pixel_ready_out  output  1  block can accept a pixel.
- pixel_x_in  input  9  pixel x.
- pixel_y_in  input  8  pixel y.
- centroid_x_in  input  NUM_CLUSTERS*9  flat centroid x bus; centroid k at bits [9k+8:9k].
- centroid_y_in  input  NUM_CLUSTERS*8  flat centroid y bus; centroid k at bits [8k+7:8k].
- dist_valid_out  output  1  request to distance unit (its valid_in).
- dist_x1_out  output  9  pixel x to distance unit.
- dist_y1_out  output  8  pixel y to distance unit.
- dist_x2_out  output  9  centroid x to distance unit.
- dist_y2_out  output  8  centroid y to distance unit.
- dist_valid_in  input  1  distance unit valid_out.
- dist_in  input  9  distance unit distance_out.
- cluster_valid_out  output  1  one-cycle result pulse.
- cluster_idx_out  output  IDX_W  index of nearest centroid.
- min_dist_out  output  9  distance to that centroid.
- pixel_x_out  output  9  echoed pixel x.
- pixel_y_out  output  8  echoed pixel y.

Behaviour:
- Reset (rst_n_in low, async): state IDLE; all counters, latched pixel/centroids and all outputs 0, except pixel_ready_out = 1.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: pixel_ready_out = 1. On the edge where pixel_valid_in && pixel_ready_out, latch the pixel and all centroid buses, clear issue_idx and rcv_idx, go to ISSUE. Later changes on the centroid buses have no effect on the pixel in flight.
- ISSUE: dist_valid_out = 1, dist_x1/y1 = latched pixel, dist_x2/y2 = latched centroid[issue_idx]. issue_idx increments each cycle. After issuing index NUM_CLUSTERS-1, go to WAIT.
- WAIT: dist_valid_out = 0; wait for the last distance.
- pixel_ready_out = 0 and dist_valid_out = 0 outside the states named above. Distance outputs are driven combinationally from state and latched registers.
- Distance collection (ISSUE or WAIT, dist_valid_in = 1):
  - rcv_idx 0 loads min_dist and best_idx = 0 unconditionally.
  - Later indices replace them only if dist_in < min_dist (strict unsigned 9-bit compare). Ties keep the lower index.
  - rcv_idx increments on each valid.
- Completion: on the edge that consumes distance NUM_CLUSTERS-1, register cluster_idx_out, min_dist_out and pixel_x/y_out, pulse cluster_valid_out for exactly one cycle, and return to IDLE.
- Result outputs hold their value until the next result.
- dist_valid_in in IDLE is ignored.
- Timing from the accept edge E0:
  - Requests are issued in the cycles following E0..E(K-1).
  - Result is valid in the cycle after E(K+1), where K = NUM_CLUSTERS.
  - Next accept is at E(K+2) at the earliest, so throughput is one pixel per K+2 cycles.
- No downstream backpressure: the consumer must accept cluster_valid_out whenever it pulses.
- Distance width: the unit's 9-bit sum wraps for distances above 511. This block compares the wrapped value as-is; centroid placement must keep distances at or below 511.
- Reset mid-operation:
  - Aborts immediately; no cluster_valid_out is issued for the aborted pixel.
  - Reset must be held at least 2 cycles so a stale distance return lands while in IDLE and is discarded.

Test Plan:
- K=4; centroids (10,10),(100,50),(200,200),(300,20); pixel (105,48); behavioural 1-cycle distance model -> expected distances 133,7,247,223; cluster_idx_out=1, min_dist_out=7, pixel echoed (105,48); cluster_valid_out exactly 5 cycles after the accept edge.
- Tie case: centroids (0,0),(20,0),(50,50),(80,80); pixel (10,0) -> distances 10,10,90,150; cluster_idx_out=0, min_dist_out=10.
- Pixel equal to the last centroid (300,20), other centroids as in the first scenario -> cluster_idx_out=3, min_dist_out=0.
- pixel_valid_in held high with 3 different pixels -> accepts exactly 6 cycles apart; 3 cluster_valid_out pulses, each one cycle wide, with correct results; pixel_ready_out low between accepts.
- Change centroid_x_in for all clusters one cycle after accept -> result still computed from the latched values.
- Assert rst_n_in for 2 cycles during ISSUE -> all outputs 0 and pixel_ready_out=1 immediately; no result for the aborted pixel; the next pixel from the first scenario yields idx 1, dist 7.
